mem_access_unit: RTL and testbench

- Load/store front end sitting directly upstream of the word-wide data memory.
- Accepts byte/half/word load and store requests from the pipeline MEM stage and converts byte addresses to word indices.
- Drives the memory's level-sensitive ren/wen strobes with stable address and data; never asserts both strobes together.
- Performs sub-word extraction with sign/zero extension, sub-word stores by read-modify-write, and alignment checking.

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and memory-side bus bundle for mem_access_unit
interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_ren, mem_wen, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_ren, mem_wen, mem_addr, mem_din
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end: sub-word extract/extend, read-modify-write stores, alignment check
// Optional big-endian lane mapping when MEM_ACCESS_BIG_ENDIAN_EN is defined.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t            r_state;
  logic              r_ready;
  logic              r_ren;
  logic              r_wen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [DATA_W-1:0] r_wdata;

  logic              w_req_err;
  logic              w_word_store;
  logic [4:0]        w_shift;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_merged;

  assign w_req_err = (bus.req_size == 2'b11) ||
                     (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                     (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign w_word_store = bus.req_we && (bus.req_size == 2'b10);

  // Bit offset of the addressed lane inside the memory word.
  always_comb begin
    w_shift = 5'd0;
    if (r_size == 2'b00) begin
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
      w_shift = 5'd24 - {r_off, 3'b000};
`else
      w_shift = {r_off, 3'b000};
`endif
    end else if (r_size == 2'b01) begin
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
      w_shift = r_off[1] ? 5'd0 : 5'd16;
`else
      w_shift = r_off[1] ? 5'd16 : 5'd0;
`endif
    end
  end

  assign w_lane = bus.mem_dout >> w_shift;

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{(DATA_W-8){r_signed & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_load = {{(DATA_W-16){r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load = bus.mem_dout;
    endcase
  end

  assign w_mask   = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_shift;
  assign w_merged = (bus.mem_dout & ~w_mask) | ((r_wdata << w_shift) & w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_ren        <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_din        <= '0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && r_ready) begin
            r_we     <= bus.req_we;
            r_size   <= bus.req_size;
            r_signed <= bus.req_signed;
            r_off    <= bus.req_addr[1:0];
            r_wdata  <= bus.req_wdata;
            r_addr   <= {2'b00, bus.req_addr[ADDR_W-1:2]};
            r_ready  <= 1'b0;
            if (w_req_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end else if (w_word_store) begin
              r_state <= S_WR;
              r_wen   <= 1'b1;
              r_din   <= bus.req_wdata;
            end else begin
              r_state <= S_RD;
              r_ren   <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_ren <= 1'b0;
          if (r_we) begin
            r_state <= S_WR;
            r_wen   <= 1'b1;
            r_din   <= w_merged;
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_load;
            r_err        <= 1'b0;
          end
        end
        S_WR: begin
          r_wen        <= 1'b0;
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_rdata      <= '0;
          r_err        <= 1'b0;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_rdata      <= '0;
          r_err        <= 1'b0;
          r_ready      <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.mem_ren    = r_ren;
  assign bus.mem_wen    = r_wen;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_din    = r_din;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a byte-addressed reference model
module tb_mem_access_unit;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   ren_cycles;
  int   wen_cycles;
  int   overlap;
  logic [31:0] wen_addr;

  logic [31:0] dut_mem [0:63];
  logic [31:0] ref_mem [0:63];

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_dout = bus.mem_ren ? dut_mem[bus.mem_addr[5:0]] : 32'hDEAD_0BAD;

  always @(posedge clk) begin
    if (bus.mem_wen) dut_mem[bus.mem_addr[5:0]] <= bus.mem_din;
  end

  always @(negedge clk) begin
    if (bus.mem_ren) ren_cycles++;
    if (bus.mem_wen) begin
      wen_cycles++;
      wen_addr = bus.mem_addr;
    end
  end

  always @(bus.mem_ren or bus.mem_wen) begin
    if (bus.mem_ren && bus.mem_wen) overlap++;
  end

  // Reference: memory seen as bytes; byte address a lives at a fixed bit position of word a/4.
  function automatic int lane_pos(input logic [7:0] a);
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
    return 24 - 8 * int'(a[1:0]);
`else
    return 8 * int'(a[1:0]);
`endif
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [1:0] size, input logic [7:0] a);
    int n;
    if (size == 2'd3) return 1'b1;
    n = nbytes(size);
    return (int'(a) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] size, input logic sgn);
    int n;
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  ai;
    n = nbytes(size);
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
      b  = 8'((ref_mem[ai[7:2]] >> lane_pos(ai)) & 32'hFF);
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
      v = v | (32'(b) << (8 * (n - 1 - i)));
`else
      v = v | (32'(b) << (8 * i));
`endif
    end
    if (sgn && n < 4 && ((v >> (8 * n - 1)) & 32'd1) == 32'd1)
      v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic model_store(input logic [7:0] a, input logic [1:0] size, input logic [31:0] d);
    int n;
    int pos;
    logic [7:0] b;
    logic [7:0] ai;
    n = nbytes(size);
    for (int i = 0; i < n; i++) begin
      ai = a + 8'(i);
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
      b = 8'(d >> (8 * (n - 1 - i)));
`else
      b = 8'(d >> (8 * i));
`endif
      pos = lane_pos(ai);
      ref_mem[ai[7:2]] = (ref_mem[ai[7:2]] & ~(32'hFF << pos)) | (32'(b) << pos);
    end
  endtask

  // Called at a falling edge; returns at the falling edge of the response cycle.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int waitc);
    ren_cycles     = 0;
    wen_cycles     = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat   = 0;
    rdata = 32'hFFFF_FFFF;
    err   = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat   = c;
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b ren=%b wen=%b required 1 0 0", bus.req_ready, bus.mem_ren, bus.mem_wen);
    end
    checks++;
    if (bus.mem_addr !== 32'd0 || bus.mem_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem: addr=%h din=%h required 0 0", bus.mem_addr, bus.mem_din);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'd0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_resp: valid=%b rdata=%h err=%b required 0 0 0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
  endtask

  task automatic test_reset_mid_rd;
    int seen;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'd2;
    bus.req_signed = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = 32'd0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_ren !== 1'b1) begin
      errors++;
      $display("FAIL midrd_ren: ren=%b required 1", bus.mem_ren);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_ren !== 1'b0 || bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrd_async: ren=%b ready=%b valid=%b required 0 1 0", bus.mem_ren, bus.req_ready, bus.resp_valid);
    end
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    checks++;
    if (seen !== 0 || dut.r_state !== 2'd0) begin
      errors++;
      $display("FAIL midrd_noresp: resp pulses=%0d state=%0d required 0 0", seen, dut.r_state);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat; int wc;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, wc);
    model_store(8'h10, 2'd2, 32'hDEAD_BEEF);
    checks++;
    if (lat !== 2 || er !== 1'b0 || wen_cycles !== 1 || ren_cycles !== 0 || wen_addr !== 32'd4) begin
      errors++;
      $display("FAIL word_store: lat=%0d err=%b wen=%0d ren=%0d addr=%h required 2 0 1 0 4", lat, er, wen_cycles, ren_cycles, wen_addr);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat !== 2 || ren_cycles !== 1) begin
      errors++;
      $display("FAIL word_load: rdata=%h err=%b lat=%0d ren=%0d required deadbeef 0 2 1", rd, er, lat, ren_cycles);
    end
  endtask

  task automatic test_subword;
    logic [31:0] rd; logic er; int lat; int wc; int ov0;
    logic [31:0] exp_word; logic [31:0] exp_sb; logic [31:0] exp_ub; logic [31:0] exp_sh;
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
    exp_word = 32'h11AA_3344; exp_sb = 32'hFFFF_FFAA; exp_ub = 32'h0000_00AA; exp_sh = 32'h0000_3344;
`else
    exp_word = 32'h1122_AA44; exp_sb = 32'hFFFF_FFAA; exp_ub = 32'h0000_00AA; exp_sh = 32'h0000_1122;
`endif
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, rd, er, lat, wc);
    model_store(8'h10, 2'd2, 32'h1122_3344);
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== 32'h0000_0011) begin
      errors++;
      $display("FAIL be_byte: rdata=%h required 00000011", rd);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== 32'h0000_3344) begin
      errors++;
      $display("FAIL be_half: rdata=%h required 00003344", rd);
    end
`endif
    ov0 = overlap;
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56AA, rd, er, lat, wc);
    model_store(8'h11, 2'd0, 32'h1234_56AA);
    checks++;
    if (lat !== 3 || er !== 1'b0 || ren_cycles !== 1 || wen_cycles !== 1 || overlap !== ov0) begin
      errors++;
      $display("FAIL byte_store: lat=%0d err=%b ren=%0d wen=%0d overlap=%0d required 3 0 1 1 0", lat, er, ren_cycles, wen_cycles, overlap - ov0);
    end
    checks++;
    if (dut_mem[4] !== exp_word || ref_mem[4] !== exp_word) begin
      errors++;
      $display("FAIL byte_merge: mem=%h model=%h required %h", dut_mem[4], ref_mem[4], exp_word);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== exp_sb || rd !== model_load(8'h11, 2'd0, 1'b1) || lat !== 2) begin
      errors++;
      $display("FAIL sbyte_load: rdata=%h lat=%0d required %h 2", rd, lat, exp_sb);
    end
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== exp_ub || rd !== model_load(8'h11, 2'd0, 1'b0)) begin
      errors++;
      $display("FAIL ubyte_load: rdata=%h required %h", rd, exp_ub);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, er, lat, wc);
    checks++;
    if (rd !== exp_sh || rd !== model_load(8'h12, 2'd1, 1'b1)) begin
      errors++;
      $display("FAIL shalf_load: rdata=%h required %h", rd, exp_sh);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat; int wc;
    do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, rd, er, lat, wc);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || ren_cycles !== 0 || wen_cycles !== 0) begin
      errors++;
      $display("FAIL err_word_load: err=%b rdata=%h lat=%0d ren=%0d wen=%0d required 1 0 1 0 0", er, rd, lat, ren_cycles, wen_cycles);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h01, 32'hFFFF, rd, er, lat, wc);
    checks++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || ren_cycles !== 0 || wen_cycles !== 0) begin
      errors++;
      $display("FAIL err_half_store: err=%b rdata=%h lat=%0d ren=%0d wen=%0d required 1 0 1 0 0", er, rd, lat, ren_cycles, wen_cycles);
    end
    do_req(1'b0, 2'd3, 1'b0, 32'h08, 32'd0, rd, er, lat, wc);
    checks++;
    if (er !== 1'b1 || lat !== 1 || ren_cycles !== 0) begin
      errors++;
      $display("FAIL err_size: err=%b lat=%0d ren=%0d required 1 1 0", er, lat, ren_cycles);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat; int wc;
    do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_F00D, rd, er, lat, wc);
    model_store(8'h24, 2'd2, 32'hCAFE_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'd0, rd, er, lat, wc);
    checks++;
    if (wc !== 1 || rd !== 32'hCAFE_F00D || lat !== 2) begin
      errors++;
      $display("FAIL b2b_load: wait=%0d rdata=%h lat=%0d required 1 cafef00d 2", wc, rd, lat);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h26, 32'd0, rd, er, lat, wc);
    checks++;
    if (wc !== 1 || rd !== model_load(8'h26, 2'd1, 1'b1)) begin
      errors++;
      $display("FAIL b2b_half: wait=%0d rdata=%h required 1 %h", wc, rd, model_load(8'h26, 2'd1, 1'b1));
    end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic er; int lat; int wc;
    logic        we; logic [1:0] size; logic sgn; logic [7:0] a; logic [31:0] d;
    logic        e_err; logic [31:0] e_rd; int e_lat; int e_ren; int e_wen;
    for (int w = 0; w < 64; w++) begin
      d = $urandom;
      do_req(1'b1, 2'd2, 1'b0, 32'(w * 4), d, rd, er, lat, wc);
      model_store(8'(w * 4), 2'd2, d);
    end
    for (int k = 0; k < 120; k++) begin
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      a    = 8'($urandom_range(0, 255));
      d    = $urandom;
      if ($urandom_range(0, 3) != 0 && size != 2'd3) a = a & ~8'(nbytes(size) - 1);
      e_err = model_err(size, a);
      e_rd  = (we || e_err) ? 32'd0 : model_load(a, size, sgn);
      e_lat = e_err ? 1 : (we && size != 2'd2) ? 3 : 2;
      e_ren = (!e_err && !(we && size == 2'd2)) ? 1 : 0;
      e_wen = (!e_err && we) ? 1 : 0;
      do_req(we, size, sgn, {24'd0, a}, d, rd, er, lat, wc);
      if (we && !e_err) model_store(a, size, d);
      checks++;
      if (rd !== e_rd || er !== e_err || lat !== e_lat || ren_cycles !== e_ren || wen_cycles !== e_wen) begin
        errors++;
        $display("FAIL rand_%0d: we=%b size=%0d a=%h rdata=%h err=%b lat=%0d ren=%0d wen=%0d required %h %b %0d %0d %0d",
                 k, we, size, a, rd, er, lat, ren_cycles, wen_cycles, e_rd, e_err, e_lat, e_ren, e_wen);
      end
    end
    for (int w = 0; w < 64; w++) begin
      checks++;
      if (dut_mem[w] !== ref_mem[w]) begin
        errors++;
        $display("FAIL mem_word_%0d: got=%h required %h", w, dut_mem[w], ref_mem[w]);
      end
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL strobe_overlap: count=%0d required 0", overlap);
    end
  endtask

  initial begin
    errors = 0; checks = 0; ren_cycles = 0; wen_cycles = 0; overlap = 0; wen_addr = 32'd0;
    for (int w = 0; w < 64; w++) ref_mem[w] = 32'd0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset_mid_rd;
    test_word;
    test_subword;
    test_errors;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
